// File: rtl/maj_tt_scanner.sv
// Sweeps every minterm of an NIN-input network, captures its truth table after
// LAT cycles of network latency, then registers ones count, self-duality and monotonicity.
module maj_tt_scanner #(
  parameter int NIN = 7,
  parameter int LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [NIN-1:0]     x_out,
  output logic               x_valid,
  input  logic               f_in,
  output logic               busy,
  output logic               done,
  output logic               result_valid,
  output logic [2**NIN-1:0]  tt,
  output logic [NIN:0]       ones,
  output logic               self_dual,
  output logic               monotone,
  output logic [2:0]         dbg_state
);
  localparam int TTW = 2**NIN;
  localparam int PL  = (LAT > 0) ? LAT : 1;
  localparam logic [NIN:0] LAST = (NIN+1)'(TTW - 1);

  typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_DRAIN, S_CHECK, S_DONE} state_t;

  state_t            r_state;
  logic [NIN:0]      r_cnt;
  logic [1:0]        r_dcnt;
  logic [NIN-1:0]    r_xo;
  logic              r_xv;
  logic              r_busy;
  logic              r_done;
  logic              r_rv;
  logic [TTW-1:0]    r_tt;
  logic [NIN:0]      r_ones;
  logic              r_sd;
  logic              r_mono;
  logic [PL-1:0]     r_pv;
  logic [NIN-1:0]    r_pi [PL];

  logic              w_cap_v;
  logic [NIN-1:0]    w_cap_i;
  logic              w_sd;
  logic              w_mono;
  logic              w_last;

  // x_valid qualifies x_out; there is no backpressure, the network must accept one minterm per cycle.
  assign w_cap_v = (LAT == 0) ? r_xv : r_pv[PL-1];
  assign w_cap_i = (LAT == 0) ? r_xo : r_pi[PL-1];
  assign w_last  = (r_cnt == LAST);

  always_comb begin
    w_sd   = 1'b1;
    w_mono = 1'b1;
    for (int k = 0; k < TTW; k++) begin
      if (r_tt[k] == r_tt[TTW-1-k]) w_sd = 1'b0;
      for (int j = 0; j < NIN; j++) begin
        if (!k[j] && r_tt[k] && !r_tt[k | (1 << j)]) w_mono = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_xo    <= '0;
      r_xv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rv    <= 1'b0;
      r_tt    <= '0;
      r_ones  <= '0;
      r_sd    <= 1'b0;
      r_mono  <= 1'b0;
      r_pv    <= '0;
      for (int i = 0; i < PL; i++) r_pi[i] <= '0;
    end else begin
      r_pv[0] <= r_xv;
      r_pi[0] <= r_xo;
      for (int i = 1; i < PL; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pi[i] <= r_pi[i-1];
      end
      r_done <= 1'b0;
      if (w_cap_v) begin
        r_tt[w_cap_i] <= f_in;
        if (f_in) r_ones <= r_ones + (NIN+1)'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
            r_xo    <= '0;
            r_xv    <= 1'b1;
            r_busy  <= 1'b1;
            r_rv    <= 1'b0;
            r_tt    <= '0;
            r_ones  <= '0;
            r_sd    <= 1'b0;
            r_mono  <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_xv    <= 1'b0;
            r_busy  <= 1'b0;
            r_pv    <= '0;
          end else if (w_last) begin
            r_xv    <= 1'b0;
            r_dcnt  <= 2'(LAT - 1);
            r_state <= (LAT == 0) ? S_CHECK : S_DRAIN;
          end else begin
            r_cnt <= r_cnt + (NIN+1)'(1);
            r_xo  <= r_cnt[NIN-1:0] + NIN'(1);
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pv    <= '0;
          end else if (r_dcnt == 2'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_dcnt <= r_dcnt - 2'd1;
          end
        end
        S_CHECK: begin
          r_sd    <= w_sd;
          r_mono  <= w_mono;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_rv    <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_out        = r_xo;
  assign x_valid      = r_xv;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_rv;
  assign tt           = r_tt;
  assign ones         = r_ones;
  assign self_dual    = r_sd;
  assign monotone     = r_mono;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_maj_tt_scanner.sv
// Bench for maj_tt_scanner: one LAT=0 and one LAT=2 instance driven by bench-side
// network functions, checked cycle by cycle against a timeline/truth-table model.
module tb_maj_tt_scanner;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t0[2];
  logic exp_rv[2];
  int   fn[2];

  logic st0, ab0, st2, ab2;
  logic [6:0] xo0, xo2;
  logic xv0, xv2, bsy0, bsy2, dn0, dn2, rv0, rv2, sd0, sd2, mo0, mo2;
  logic f0, f2, r_n1, r_n2;
  logic [127:0] tt0, tt2;
  logic [7:0] on0, on2;
  logic [2:0] ds0, ds2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maj_tt_scanner #(.NIN(7), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .abort(ab0), .x_out(xo0), .x_valid(xv0),
    .f_in(f0), .busy(bsy0), .done(dn0), .result_valid(rv0), .tt(tt0), .ones(on0),
    .self_dual(sd0), .monotone(mo0), .dbg_state(ds0));

  maj_tt_scanner #(.NIN(7), .LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .abort(ab2), .x_out(xo2), .x_valid(xv2),
    .f_in(f2), .busy(bsy2), .done(dn2), .result_valid(rv2), .tt(tt2), .ones(on2),
    .self_dual(sd2), .monotone(mo2), .dbg_state(ds2));

  // Networks under test: 0 maj(x0,x1,x2), 1 const 0, 2 x0^x1^x2, 3 x0&x1
  function automatic logic netf(input int f, input logic [6:0] x);
    case (f)
      0: return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      2: return x[0] ^ x[1] ^ x[2];
      3: return x[0] & x[1];
      default: return 1'b0;
    endcase
  endfunction

  assign f0 = netf(fn[0], xo0);
  always @(posedge clk) begin
    r_n1 <= netf(fn[1], xo2);
    r_n2 <= r_n1;
  end
  assign f2 = r_n2;

  function automatic logic [127:0] model_tt(input int f);
    logic [127:0] m;
    for (int k = 0; k < 128; k++) m[k] = netf(f, 7'(k));
    return m;
  endfunction

  function automatic logic model_sd(input logic [127:0] t);
    for (int k = 0; k < 128; k++) if (t[k] == t[127-k]) return 1'b0;
    return 1'b1;
  endfunction

  // Monotone: every pair a <= b (bitwise subset) must satisfy f(a) <= f(b).
  function automatic logic model_mono(input logic [127:0] t);
    for (int a = 0; a < 128; a++)
      for (int b = 0; b < 128; b++)
        if (((a & ~b) == 0) && t[a] && !t[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cmp(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk(input int id, input int lat, input logic [6:0] xo, input logic xv,
                     input logic bsy, input logic dn, input logic rv, input logic [127:0] t,
                     input logic [7:0] on, input logic sd, input logic mo);
    int d;
    logic [127:0] m;
    if (t0[id] >= 0 && cyc > t0[id]) begin
      d = cyc - t0[id];
      exp_rv[id] = 1'b0;
      cmp($sformatf("dut%0d_ctl", id), 128'({xv, bsy, dn, rv}),
          128'({d <= 128, d <= 129 + lat, d == 130 + lat, d == 130 + lat}));
      if (d <= 128 + lat) cmp($sformatf("dut%0d_xout", id), 128'(xo), 128'((d <= 128) ? d - 1 : 127));
      if (d == 130 + lat) begin
        m = model_tt(fn[id]);
        cmp($sformatf("dut%0d_tt", id), t, m);
        cmp($sformatf("dut%0d_ones", id), 128'(on), 128'($countones(m)));
        cmp($sformatf("dut%0d_flags", id), 128'({sd, mo}), 128'({model_sd(m), model_mono(m)}));
        t0[id] = -1;
        exp_rv[id] = 1'b1;
      end
    end else begin
      cmp($sformatf("dut%0d_idle", id), 128'({xv, bsy, dn, rv}), 128'({3'b000, exp_rv[id]}));
    end
  endtask

  always @(negedge clk) begin
    chk(0, 0, xo0, xv0, bsy0, dn0, rv0, tt0, on0, sd0, mo0);
    chk(1, 2, xo2, xv2, bsy2, dn2, rv2, tt2, on2, sd2, mo2);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_dut(input int id, output int sc);
    if (id == 0) st0 = 1'b1; else st2 = 1'b1;
    t0[id] = cyc;
    sc = cyc;
    tick();
    st0 = 1'b0;
    st2 = 1'b0;
  endtask

  task automatic wait_done(input int id, input int lat, input int sc, input string nm);
    int n = 0;
    while (!(id == 0 ? dn0 : dn2) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      bad++;
      total++;
      t0[id] = -1;
      $display("FAIL %s_timeout got=no_done exp=done", nm);
    end else begin
      cmp({nm, "_latency"}, 128'(cyc - sc), 128'(130 + lat));
    end
  endtask

  task automatic wait_x0(input int v);
    int n = 0;
    while (!(xv0 && xo0 == 7'(v)) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      bad++;
      total++;
      $display("FAIL wait_x0_%0d got=timeout exp=x_out_seen", v);
    end
  endtask

  logic [127:0] lit_tt[4];
  int           lit_ones[4] = '{64, 0, 64, 32};
  logic [1:0]   lit_flags[4] = '{2'b11, 2'b01, 2'b10, 2'b01};

  initial begin
    int sc;
    lit_tt[0] = {16{8'hE8}};
    lit_tt[1] = '0;
    lit_tt[2] = {16{8'h96}};
    lit_tt[3] = {16{8'h88}};
    rst_n = 1'b0;
    st0 = 1'b0; ab0 = 1'b0; st2 = 1'b0; ab2 = 1'b0;
    fn[0] = 0; fn[1] = 0;
    t0[0] = -1; t0[1] = -1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    repeat (3) tick();
    cmp("rst_dut0_out", 128'({xo0, xv0, bsy0, dn0, rv0, on0, sd0, mo0}), 128'(0));
    cmp("rst_dut0_tt", tt0, 128'(0));
    cmp("rst_dut2_out", 128'({xo2, xv2, bsy2, dn2, rv2, on2, sd2, mo2}), 128'(0));
    rst_n = 1'b1;
    tick();

    for (int f = 0; f < 4; f++) begin
      fn[0] = f;
      start_dut(0, sc);
      wait_done(0, 0, sc, $sformatf("lat0_f%0d", f));
      cmp($sformatf("lit_tt_f%0d", f), tt0, lit_tt[f]);
      cmp($sformatf("lit_ones_f%0d", f), 128'(on0), 128'(lit_ones[f]));
      cmp($sformatf("lit_flags_f%0d", f), 128'({sd0, mo0}), 128'(lit_flags[f]));
      repeat (3) tick();
    end

    fn[1] = 0;
    start_dut(1, sc);
    while (cyc < sc + 5) tick();
    st2 = 1'b1; tick(); st2 = 1'b0;
    while (cyc < sc + 50) tick();
    st2 = 1'b1; tick(); st2 = 1'b0;
    wait_done(1, 2, sc, "lat2_maj");
    cmp("lit_tt_lat2", tt2, lit_tt[0]);
    cmp("lit_ones_lat2", 128'(on2), 128'(64));
    repeat (3) tick();

    fn[0] = 0;
    start_dut(0, sc);
    wait_x0(60);
    ab0 = 1'b1;
    tick();
    ab0 = 1'b0;
    t0[0] = -1;
    exp_rv[0] = 1'b0;
    cmp("abort_idle", 128'({xv0, bsy0, dn0, rv0}), 128'(0));
    repeat (140) tick();
    fn[0] = 3;
    start_dut(0, sc);
    wait_done(0, 0, sc, "after_abort");
    cmp("lit_tt_after_abort", tt0, lit_tt[3]);
    repeat (3) tick();

    fn[0] = 0;
    start_dut(0, sc);
    wait_x0(100);
    rst_n = 1'b0;
    t0[0] = -1; t0[1] = -1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    #1;
    cmp("midrst_dut0_out", 128'({xo0, xv0, bsy0, dn0, rv0, on0, sd0, mo0}), 128'(0));
    cmp("midrst_dut0_tt", tt0, 128'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fn[0] = 2;
    start_dut(0, sc);
    wait_done(0, 0, sc, "after_reset");
    cmp("lit_tt_after_reset", tt0, lit_tt[2]);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
